// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the 8-bit CPU: owns the program counter and reads instruction
// bytes from program RAM. Each byte is handed to control_block as opcode/operand
// over a valid/ready handshake. The stage also handles jumps and HLT.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   mem_addr     RAM read address; this is the pc itself
//   mem_rd_req   RAM read request, held until mem_rd_ack
//   mem_rd_ack   RAM data valid on mem_rd_data this cycle
//   mem_rd_data  instruction byte
//   instr_valid  opcode/operand valid to control_block
//   instr_ready  control_block accepts the instruction
//   opcode       instruction bits [7:4]
//   operand      instruction bits [3:0]
//   jump_en      load jump_addr into pc; sampled on the handshake cycle only
//   jump_addr    jump target
//   pc_out       current program counter (debug)
//   halted       HLT accepted; fetching stopped until reset
module instruction_fetch_unit #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned OPCODE_W = 4,
  parameter logic [OPCODE_W-1:0] HLT_OPCODE = OPCODE_W'(4'hF)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd_req,
  input  logic                mem_rd_ack,
  input  logic [7:0]          mem_rd_data,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [OPCODE_W-1:0] opcode,
  output logic [3:0]          operand,
  input  logic                jump_en,
  input  logic [ADDR_W-1:0]   jump_addr,
  output logic [ADDR_W-1:0]   pc_out,
  output logic                halted
);

  localparam int unsigned INSTR_W   = 8;
  localparam int unsigned OPERAND_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      pc_q, pc_d;
  logic [OPCODE_W-1:0]    opcode_q, opcode_d;
  logic [OPERAND_W-1:0]   operand_q, operand_d;
  logic                   req_q, valid_q, halted_q;

  // State and datapath registers; the flag outputs are flops loaded from the
  // next state, so an async reset drops mem_rd_req immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      opcode_q  <= '0;
      operand_q <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      req_q     <= (state_d == REQ);
      valid_q   <= (state_d == HOLD);
      halted_q  <= (state_d == HALT);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (mem_rd_ack) begin
          opcode_d  = mem_rd_data[INSTR_W-1 -: OPCODE_W];
          operand_d = mem_rd_data[OPERAND_W-1:0];
          pc_d      = pc_q + ADDR_W'(1);
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          // HLT wins over a simultaneous jump request.
          if (opcode_q == HLT_OPCODE) begin
            state_d = HALT;
          end else begin
            if (jump_en) pc_d = jump_addr;
            state_d = REQ;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr    = pc_q;
  assign pc_out      = pc_q;
  assign mem_rd_req  = req_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign opcode      = opcode_q;
  assign operand     = operand_q;

endmodule
